early_debouncer: RTL and testbench



---
 rtl/early_debouncer.sv | 118 +++++++++++
 tb/tb_early_debouncer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/early_debouncer.sv
// Early-detection switch debouncer: the first edge of sw passes straight through, then
// the input is ignored for N_TICKS tick strobes. Define SYNC_EN to add a 2-flop input synchronizer.
module early_debouncer #(
  parameter int N_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sw,
  output logic db_level,
  output logic db_tick,
  output logic busy
);

  localparam int CW = $clog2(N_TICKS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_nextCnt;
  logic            w_swS;
  logic            w_nextLevel;
  logic            w_nextTick;
  logic            w_nextBusy;
  logic            w_lockDone;

`ifdef SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for a pin that is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_swS = r_sync2;
`else
  assign w_swS = sw;
`endif

  assign w_lockDone = tick && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ZERO;
      r_cnt    <= '0;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      db_level <= w_nextLevel;
      db_tick  <= w_nextTick;
      busy     <= w_nextBusy;
    end
  end

  // Lockout states ignore sw_s entirely; a tick on the entry edge is never counted.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextTick  = 1'b0;
    unique case (r_state)
      ZERO: begin
        if (w_swS) begin
          w_nextState = WAIT1;
          w_nextCnt   = '0;
          w_nextTick  = 1'b1;
        end
      end
      WAIT1: begin
        if (w_lockDone) begin
          w_nextState = ONE;
        end else if (tick) begin
          w_nextCnt = r_cnt + CW'(1);
        end
      end
      ONE: begin
        if (!w_swS) begin
          w_nextState = WAIT0;
          w_nextCnt   = '0;
        end
      end
      WAIT0: begin
        if (w_lockDone) begin
          w_nextState = ZERO;
        end else if (tick) begin
          w_nextCnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_nextState = ZERO;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_nextLevel = (w_nextState == WAIT1) || (w_nextState == ONE);
    w_nextBusy  = (w_nextState == WAIT1) || (w_nextState == WAIT0);
  end

endmodule

// File: tb/tb_early_debouncer.sv
// Self-checking bench for early_debouncer: a vector table for the tick-held cases plus
// hand-written sequences for reset, early detect, release and synchronizer latency.
module tb_early_debouncer;

  localparam int N_TICKS = 4;
`ifdef SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic sw;
  logic db_level;
  logic db_tick;
  logic busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic sw;
    logic tick;
    logic expL;
    logic expT;
    logic expB;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  early_debouncer #(.N_TICKS(N_TICKS)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick),
    .busy     (busy)
  );

  // Free-running 10-unit clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic t);
    sw   = s;
    tick = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic expL, input logic expT, input logic expB);
    total++;
    if (db_level !== expL || db_tick !== expT || busy !== expB) begin
      bad++;
      $display("[TB] FAIL %s t=%0t: got level=%b tick=%b busy=%b, want level=%b tick=%b busy=%b",
               name, $time, db_level, db_tick, busy, expL, expT, expB);
    end
  endtask

  // Main sequence: every step is one clock, so no open-ended waits exist.
  initial begin
    // Tick held high: 2-clk sw pulse, then a tick-gated lockout and an immediate re-trigger.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[25] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[26] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    sw    = 1'b0;
    tick  = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, (i % 10) == 9);
      checkOutput("reset_idle", 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;

    // The table's sw column is the FSM's view; lead it by the synchronizer depth.
    for (int p = 0; p < SD; p++) begin
      applyStimulus(vecs[p].sw, 1'b0);
      checkOutput("preroll", 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < NV; i++) begin
      int idx;
      idx = (i + SD < NV) ? i + SD : NV - 1;
      applyStimulus(vecs[idx].sw, vecs[i].tick);
      checkOutput($sformatf("vec%0d", i), vecs[i].expL, vecs[i].expT, vecs[i].expB);
    end

    // Now in WAIT1 with cnt=2: reset between edges must clear outputs at once.
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_hold", 1'b0, 1'b0, 1'b0);

    // Release with sw=1 and tick held: re-entry into WAIT1 with a fresh count.
    reset = 1'b0;
    for (int k = 0; k < SD + 6; k++) begin
      logic eL, eT, eB;
      eL = (k >= SD);
      eT = (k == SD);
      eB = (k >= SD) && (k <= SD + 3);
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("restart%0d", k), eL, eT, eB);
    end

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset2", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Early detect at cyc 100 with bounce, release at cyc 140 with bounce; ticks at cyc%10==5.
    for (int cyc = 0; cyc < 186; cyc++) begin
      logic s, eL, eT, eB;
      if (cyc < 100)       s = 1'b0;
      else if (cyc < 125)  s = (((cyc - 100) / 3) % 2) == 0;
      else if (cyc < 140)  s = 1'b1;
      else if (cyc < 160)  s = (((cyc - 140) / 3) % 2) == 1;
      else                 s = 1'b0;
      eL = (cyc >= 100 + SD) && (cyc < 140 + SD);
      eT = (cyc == 100 + SD);
      eB = ((cyc >= 100 + SD) && (cyc <= 134)) || ((cyc >= 140 + SD) && (cyc <= 174));
      applyStimulus(s, (cyc % 10) == 5);
      checkOutput($sformatf("bounce_cyc%0d", cyc), eL, eT, eB);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
